// File: rtl/ps2_note_keys_pkg.sv
// Shared PS/2 constants, default note scancodes and receiver state encoding.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Scan-code set 2 makes for the A/S/D/F note keys
  localparam logic [7:0] KEY0_DEF = 8'h1C;
  localparam logic [7:0] KEY1_DEF = 8'h1B;
  localparam logic [7:0] KEY2_DEF = 8'h23;
  localparam logic [7:0] KEY3_DEF = 8'h2B;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones
  function automatic logic odd_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_note_keys_rx.sv
// PS/2 device-to-host frame receiver: input sync, ps2_clk deglitch filter,
// 11-bit frame FSM and mid-frame timeout. Emits one byte/valid or err pulse per frame.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic [FW-1:0] flt_cnt;
  logic          flt_clk;
  logic          strobe;
  logic          sdat;
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] to_cnt;

  // Two-flop synchronizers; the bus idles high so reset to 1
  always_ff @(posedge clock) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples;
  // the 1->0 flip raises a one-cycle strobe with the data bit captured alongside.
  always_ff @(posedge clock) begin
    if (!reset) begin
      flt_cnt <= '0;
      flt_clk <= 1'b1;
      strobe  <= 1'b0;
      sdat    <= 1'b1;
    end else begin
      strobe <= 1'b0;
      sdat   <= dat_sync[1];
      if (clk_sync[1] == flt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt_cnt <= '0;
        flt_clk <= clk_sync[1];
        strobe  <= flt_clk;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // Frame FSM: one step per strobe; the idle timer aborts a stalled frame.
  // A strobe always wins over the timer, so valid and err never coincide.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= RX_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      to_cnt   <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (strobe) begin
        to_cnt <= '0;
        case (state)
          RX_IDLE: begin
            if (!sdat) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            shreg   <= {sdat, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            par   <= sdat;
            state <= RX_STOP;
          end
          RX_STOP: begin
            state <= RX_IDLE;
            if (sdat && odd_ok(shreg, par)) begin
              rx_valid <= 1'b1;
              rx_byte  <= shreg;
            end else begin
              rx_err <= 1'b1;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end else if (state != RX_IDLE) begin
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          rx_err <= 1'b1;
          state  <= RX_IDLE;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_note_keys.sv
// PS/2 keyboard front end: receiver plus make/break decoder driving a 4-bit
// held-note vector. ps2_dat is input-only; the host never drives the bus.
module ps2_note_keys
  import ps2_pkg::*;
#(
  parameter int         FILTER_LEN     = 4,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] KEY0_CODE      = KEY0_DEF,
  parameter logic [7:0] KEY1_CODE      = KEY1_DEF,
  parameter logic [7:0] KEY2_CODE      = KEY2_DEF,
  parameter logic [7:0] KEY3_CODE      = KEY3_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [3:0] keys,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  logic [7:0]      rx_byte;
  logic            rx_valid, rx_err;
  logic            ext, brk;
  logic [3:0][7:0] key_codes;
  logic [3:0]      key_hit;

  assign key_codes = {KEY3_CODE, KEY2_CODE, KEY1_CODE, KEY0_CODE};

  for (genvar n = 0; n < 4; n++) begin : g_hit
    assign key_hit[n] = (rx_byte == key_codes[n]);
  end

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock   (clock),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  // Prefix flags accumulate E0/F0; the next plain byte applies them to a
  // mapped key (non-extended only) and clears them. Frame errors leave flags alone.
  always_ff @(posedge clock) begin
    if (!reset) begin
      keys       <= '0;
      scan_valid <= 1'b0;
      scan_code  <= '0;
      frame_err  <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
    end else begin
      scan_valid <= rx_valid;
      frame_err  <= rx_err;
      if (rx_valid) begin
        scan_code <= rx_byte;
        if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_BREAK) begin
          brk <= 1'b1;
        end else begin
          if (!ext) begin
            for (int n = 0; n < 4; n++) begin
              if (key_hit[n]) keys[n] <= ~brk;
            end
          end
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_note_keys.sv
// Self-checking bench for ps2_note_keys. PS/2 timing is scaled down (48-cycle bit
// period, short timeout) so the run stays short; 5-cycle ps2_clk glitches sit
// below the bench's FILTER_LEN of 8 and must be rejected.
module tb_ps2_note_keys;

  localparam int FLT  = 8;
  localparam int TMO  = 300;
  localparam int HALF = 24;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [3:0] keys;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       frame_err;

  int total = 0;
  int bad   = 0;

  int sv_cnt = 0, fe_cnt = 0, both_cnt = 0, misalign = 0;
  logic [3:0] prev_keys = 4'd0;

  // Reference model: set of held codes plus prefix flags
  bit         held [0:255];
  bit         m_ext, m_brk;
  logic [7:0] m_code;

  ps2_note_keys #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .keys      (keys),
    .scan_valid(scan_valid),
    .scan_code (scan_code),
    .frame_err (frame_err)
  );

  always #5 clock = ~clock;

  // Pulse counters and keys/scan_valid alignment monitor
  always @(negedge clock) begin
    if (scan_valid) sv_cnt++;
    if (frame_err) fe_cnt++;
    if (scan_valid && frame_err) both_cnt++;
    if (reset && keys !== prev_keys && !scan_valid) misalign++;
    prev_keys = keys;
  end

  function automatic logic [3:0] m_keys();
    return {held[8'h2B], held[8'h23], held[8'h1B], held[8'h1C]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) held[i] = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_code = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_code = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (!m_ext) held[b] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One half period of ps2_clk at level lvl, sometimes with a short opposite blip
  task automatic half_phase(input logic lvl);
    ps2_clk = lvl;
    if ($urandom_range(0, 2) == 0) begin
      cyc(14);
      ps2_clk = ~lvl;
      cyc(5);
      ps2_clk = lvl;
      cyc(HALF - 19);
    end else begin
      cyc(HALF);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input bit flip_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = fr[i];
      half_phase(1'b1);
      half_phase(1'b0);
    end
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    cyc(40);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
    model_byte(b);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(2);
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(4);
    total++; if (keys !== 4'd0) begin bad++; $display("FAIL reset_keys got=%h want=0", keys); end
    total++; if (scan_code !== 8'd0) begin bad++; $display("FAIL reset_code got=%h want=0", scan_code); end
    total++; if (scan_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", scan_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", frame_err); end
    reset = 1'b1;
    cyc(2);
    model_clear();
  endtask

  task automatic test_make();
    int sv0, fe0;
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_byte(8'h1C);
    total++; if (sv_cnt - sv0 != 1) begin bad++; $display("FAIL make_valid got=%0d want=1", sv_cnt - sv0); end
    total++; if (fe_cnt != fe0) begin bad++; $display("FAIL make_err got=%0d want=0", fe_cnt - fe0); end
    total++; if (scan_code !== 8'h1C) begin bad++; $display("FAIL make_code got=%h want=1c", scan_code); end
    total++; if (keys !== m_keys()) begin bad++; $display("FAIL make_keys got=%b want=%b", keys, m_keys()); end
  endtask

  task automatic test_break();
    int sv0, fe0;
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_byte(8'hF0);
    send_byte(8'h1C);
    total++; if (sv_cnt - sv0 != 2) begin bad++; $display("FAIL break_valid got=%0d want=2", sv_cnt - sv0); end
    total++; if (fe_cnt != fe0) begin bad++; $display("FAIL break_err got=%0d want=0", fe_cnt - fe0); end
    total++; if (keys !== m_keys()) begin bad++; $display("FAIL break_keys got=%b want=%b", keys, m_keys()); end
  endtask

  task automatic test_multi_hold();
    logic [7:0] seq [5];
    seq = '{8'h1B, 8'h2B, 8'h23, 8'hF0, 8'h1B};
    for (int i = 0; i < 5; i++) begin
      send_byte(seq[i]);
      total++; if (keys !== m_keys()) begin bad++; $display("FAIL multi_keys step=%0d got=%b want=%b", i, keys, m_keys()); end
    end
  endtask

  task automatic test_parity();
    int sv0, fe0;
    logic [3:0] k0;
    sv0 = sv_cnt; fe0 = fe_cnt; k0 = keys;
    send_bits(8'h1C, 1'b1, 11);
    total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL parity_err got=%0d want=1", fe_cnt - fe0); end
    total++; if (sv_cnt != sv0) begin bad++; $display("FAIL parity_valid got=%0d want=0", sv_cnt - sv0); end
    total++; if (keys !== k0 || keys !== m_keys()) begin bad++; $display("FAIL parity_keys got=%b want=%b", keys, m_keys()); end
  endtask

  task automatic test_extended();
    logic [7:0] seq [5];
    seq = '{8'hE0, 8'h1C, 8'hE0, 8'hF0, 8'h1C};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_byte(seq[i]);
      total++; if (keys !== m_keys()) begin bad++; $display("FAIL ext_keys step=%0d got=%b want=%b", i, keys, m_keys()); end
    end
  endtask

  task automatic test_timeout();
    int sv0, fe0;
    do_reset();
    sv0 = sv_cnt; fe0 = fe_cnt;
    send_bits(8'h5A, 1'b0, 5);
    cyc(TMO + 100);
    total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL timeout_err got=%0d want=1", fe_cnt - fe0); end
    total++; if (sv_cnt != sv0) begin bad++; $display("FAIL timeout_valid got=%0d want=0", sv_cnt - sv0); end
    send_byte(8'h23);
    total++; if (keys !== m_keys()) begin bad++; $display("FAIL timeout_keys got=%b want=%b", keys, m_keys()); end
    // reset in the middle of a frame
    send_bits(8'h1B, 1'b0, 5);
    sv0 = sv_cnt; fe0 = fe_cnt;
    do_reset();
    cyc(TMO + 100);
    total++; if (keys !== 4'd0) begin bad++; $display("FAIL midreset_keys got=%b want=0000", keys); end
    total++; if (scan_code !== 8'd0) begin bad++; $display("FAIL midreset_code got=%h want=00", scan_code); end
    total++; if (sv_cnt != sv0 || fe_cnt != fe0) begin bad++; $display("FAIL midreset_pulses got=%0d/%0d want=0/0", sv_cnt - sv0, fe_cnt - fe0); end
    send_byte(8'h1C);
    total++; if (keys !== m_keys()) begin bad++; $display("FAIL midreset_next got=%b want=%b", keys, m_keys()); end
  endtask

  task automatic test_random();
    logic [7:0] pool [7];
    logic [7:0] b;
    int sv0, fe0;
    bit flip;
    pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'hF0, 8'hE0, 8'h00};
    for (int i = 0; i < 24; i++) begin
      b = pool[$urandom_range(0, 6)];
      if (b == 8'h00) b = 8'($urandom_range(1, 255));
      flip = ($urandom_range(0, 5) == 0);
      sv0 = sv_cnt; fe0 = fe_cnt;
      send_bits(b, flip, 11);
      if (!flip) model_byte(b);
      total++; if (keys !== m_keys()) begin bad++; $display("FAIL rand_keys step=%0d byte=%h got=%b want=%b", i, b, keys, m_keys()); end
      total++; if (scan_code !== m_code) begin bad++; $display("FAIL rand_code step=%0d got=%h want=%h", i, scan_code, m_code); end
      total++; if ((sv_cnt - sv0) != (flip ? 0 : 1) || (fe_cnt - fe0) != (flip ? 1 : 0)) begin
        bad++; $display("FAIL rand_pulses step=%0d valid=%0d err=%0d flip=%0d", i, sv_cnt - sv0, fe_cnt - fe0, flip);
      end
    end
  endtask

  task automatic test_invariants();
    total++; if (both_cnt != 0) begin bad++; $display("FAIL excl_pulses got=%0d want=0", both_cnt); end
    total++; if (misalign != 0) begin bad++; $display("FAIL keys_align got=%0d want=0", misalign); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_make();
    test_break();
    test_multi_hold();
    test_parity();
    test_extended();
    test_timeout();
    test_random();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
